// File: rtl/can_destuff_crc.sv
// CAN receive bit stage: removes stuff bits, flags stuff violations and runs
// the CRC-15 over the destuffed stream. Every state change happens on a
// sample-point strobe. The error flags are active-low and last one bit time.
module can_destuff_crc #(
  parameter int          STUFF_LEN = 5,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sp,
  input  logic        rx,
  input  logic        stuff_en,
  input  logic        crc_en,
  input  logic        crc_chk,
  output logic        bit_out,
  output logic        bit_vld,
  output logic        stuff_bit,
  output logic        stf_e,
  output logic        crc_e,
  output logic [14:0] crc_rem
);

  localparam logic [2:0] LP_LEN = 3'(STUFF_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_last;

  // One CRC-15 shift step with a single input bit folded in.
  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic n;
    n = b ^ c[14];
    return {c[13:0], 1'b0} ^ (n ? CRC_POLY : 15'd0);
  endfunction

  // Saturating run-length increment; the counter never exceeds the run length.
  function automatic logic [2:0] cnt_inc(input logic [2:0] c);
    return (c >= LP_LEN) ? LP_LEN : c + 3'd1;
  endfunction

  // Destuffing FSM, CRC register and all registered outputs, advanced on sp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_last    <= 1'b1;
      crc_rem   <= 15'd0;
      bit_out   <= 1'b1;
      bit_vld   <= 1'b0;
      stuff_bit <= 1'b0;
      stf_e     <= 1'b1;
      crc_e     <= 1'b1;
    end else begin
      bit_vld   <= 1'b0;
      stuff_bit <= 1'b0;
      if (sp) begin
        // The check looks at the remainder before this bit is folded in, in
        // every state; flags re-arm at each sp so a pulse lasts one bit time.
        crc_e <= !(crc_chk && (crc_rem != 15'd0));
        stf_e <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (stuff_en) begin
              r_state <= S_RUN;
              bit_out <= rx;
              bit_vld <= 1'b1;
              r_last  <= rx;
              r_cnt   <= 3'd1;
              crc_rem <= crc_en ? crc_step(15'd0, rx) : 15'd0;
            end
          end
          S_RUN: begin
            if (!stuff_en) begin
              // Leaving the stuffed region wins over a pending stuff check.
              r_state <= S_IDLE;
            end else if (r_cnt == LP_LEN) begin
              if (rx != r_last) begin
                stuff_bit <= 1'b1;
                r_last    <= rx;
                r_cnt     <= 3'd1;
              end else begin
                stf_e   <= 1'b0;
                r_state <= S_ERR;
              end
            end else begin
              bit_out <= rx;
              bit_vld <= 1'b1;
              if (crc_en) crc_rem <= crc_step(crc_rem, rx);
              if (rx == r_last) begin
                r_cnt <= cnt_inc(r_cnt);
              end else begin
                r_cnt  <= 3'd1;
                r_last <= rx;
              end
            end
          end
          S_ERR: begin
            if (!stuff_en) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
